mem_arbiter_n: RTL
==================

MEM_ARBITER_N -- requirements
Module: mem_arbiter_n

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requester channels; legal range 2..8.
REQ-002 Parameter s_offset, default 5: line width LINE = (2**s_offset)*8 bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 port_read  input  NUM_PORTS  per-channel line read request, bit i = channel i.
REQ-006 port_write  input  NUM_PORTS  per-channel line write request.
REQ-007 port_address  input  NUM_PORTS*32  per-channel address, channel i in bits [32i+31:32i].
REQ-008 port_wdata  input  NUM_PORTS*LINE  per-channel write line, channel i in slice i.
REQ-009 port_resp  output  NUM_PORTS  per-channel one-cycle completion pulse.
REQ-010 port_rdata  output  LINE  read line shared by all channels; valid only with port_resp.
REQ-011 mem_read  output  1  downstream (cacheline adaptor) read request.
REQ-012 mem_write  output  1  downstream write request.
REQ-013 mem_address  output  32  downstream address.
REQ-014 mem_wdata  output  LINE  downstream write line.
REQ-015 mem_rdata  input  LINE  downstream read line.
REQ-016 mem_resp  input  1  downstream completion, one cycle.

Function
REQ-017 FSM has states IDLE, BUSY, DONE.
REQ-018 IDLE: if any port_read|port_write bit set, arbitrate, register grant index, op, address, wdata of winner; next state BUSY; else stay IDLE.
REQ-019 BUSY: mem_read/mem_write driven from registered op, mem_address/mem_wdata from registered values, held stable until mem_resp.
REQ-020 BUSY with mem_resp=1: port_resp[grant]=1 same cycle, port_rdata=mem_rdata same cycle, next state DONE.
REQ-021 DONE: all outputs deasserted for one cycle, next state IDLE; prevents regrant of a request the winner drops after its resp.
REQ-022 Latency: request sampled in IDLE at cycle N, mem_read/mem_write first asserted at cycle N+1.
REQ-023 port_resp bits other than grant SHALL be 0; at most one port_resp bit set in any cycle.
REQ-024 Channel with both port_read and port_write set: write taken, read ignored for that grant.
REQ-025 Requests from non-granted channels are not acknowledged and stay pending; requesters hold them until their own resp.
REQ-026 Request inputs changing during BUSY do not affect downstream outputs.
REQ-027 mem_read and mem_write never both 1.
REQ-028 Grant index register width $clog2(NUM_PORTS).

Reset
REQ-029 rst asserted: state IDLE, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, port_resp=0, grant=0, round-robin pointer=NUM_PORTS-1, immediately regardless of clk.
REQ-030 rst asserted mid-BUSY: transaction abandoned, no port_resp issued; a late mem_resp arriving in IDLE is ignored.

Configuration
REQ-031 Macro MEM_ARBITER_RR_EN defined: round-robin; search starts at pointer+1 modulo NUM_PORTS; pointer updated to winner on each grant.
REQ-032 MEM_ARBITER_RR_EN undefined: fixed priority, lowest-index requesting channel wins; pointer logic absent.

Verification
REQ-033 NUM_PORTS=2, port_read=2'b01, addr0=0x0000_1000, mem_resp 3 cycles after mem_read -> mem_read at cycle 1, mem_address=0x0000_1000, port_resp=2'b01 with port_rdata=mem_rdata, DONE, IDLE.
REQ-034 NUM_PORTS=4, all four port_read held, RR_EN defined -> grant order 0,1,2,3,0; each port_resp pulse exactly one cycle.
REQ-035 Same stimulus, RR_EN undefined, channel 0 re-requests after each resp -> channel 0 granted every time, channels 1..3 starved.
REQ-036 Channel 1 port_write=1 and port_read=1, wdata=0xA5 pattern, addr=0x0000_2020 -> mem_write=1, mem_read=0, mem_wdata=pattern, mem_address=0x0000_2020.
REQ-037 rst pulsed two cycles into BUSY, then mem_resp -> all outputs 0 during rst, no port_resp, state IDLE; next grant goes to channel 0 under RR.
REQ-038 Channel 0 changes address to 0x0000_3000 during BUSY -> mem_address holds original value until mem_resp.

Source files
------------

// File: rtl/mem_arbiter_n_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_n_if
// Bundles the requester-side and downstream-memory-side signals of the
// N-channel line arbiter.
//   Requester side : port_read, port_write, port_address, port_wdata (to arbiter)
//                    port_resp, port_rdata (from arbiter)
//   Memory side    : mem_read, mem_write, mem_address, mem_wdata (from arbiter)
//                    mem_rdata, mem_resp (to arbiter)
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus downstream memory)
// Parameters NUM_PORTS and s_offset must match the arbiter instance.
// -----------------------------------------------------------------------------
interface mem_arbiter_n_if #(
  parameter int NUM_PORTS = 2,
  parameter int s_offset  = 5
);
  localparam int LINE = (2**s_offset) * 8;

  logic [NUM_PORTS-1:0]      port_read;
  logic [NUM_PORTS-1:0]      port_write;
  logic [NUM_PORTS*32-1:0]   port_address;
  logic [NUM_PORTS*LINE-1:0] port_wdata;
  logic [NUM_PORTS-1:0]      port_resp;
  logic [LINE-1:0]           port_rdata;

  logic                      mem_read;
  logic                      mem_write;
  logic [31:0]               mem_address;
  logic [LINE-1:0]           mem_wdata;
  logic [LINE-1:0]           mem_rdata;
  logic                      mem_resp;

  modport slave (
    input  port_read, port_write, port_address, port_wdata, mem_rdata, mem_resp,
    output port_resp, port_rdata, mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output port_read, port_write, port_address, port_wdata, mem_rdata, mem_resp,
    input  port_resp, port_rdata, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_n.sv
// -----------------------------------------------------------------------------
// mem_arbiter_n
// Arbitrates NUM_PORTS line read/write requesters onto a single downstream
// memory (cacheline adaptor) channel, one transaction at a time.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mem_arbiter_n_if.slave: per-channel requests/wdata in, one-cycle
//          per-channel completion pulse plus shared read line out, downstream
//          read/write/address/wdata out, downstream rdata/resp in.
// Build option:
//   MEM_ARBITER_RR_EN defined   -> round-robin arbitration
//   MEM_ARBITER_RR_EN undefined -> fixed priority, lowest channel index wins
// Transaction flow: IDLE (grant + capture) -> BUSY (hold until mem_resp,
// completion pulse in that same cycle) -> DONE (one quiet cycle) -> IDLE.
// -----------------------------------------------------------------------------
module mem_arbiter_n #(
  parameter int NUM_PORTS = 2,
  parameter int s_offset  = 5
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_n_if.slave bus
);
  localparam int LINE = (2**s_offset) * 8;
  localparam int GW   = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        grant_q;
  logic                 mem_read_q;
  logic                 mem_write_q;
  logic [31:0]          mem_address_q;
  logic [LINE-1:0]      mem_wdata_q;

  logic [NUM_PORTS-1:0] req_s;
  logic                 any_req_s;
  logic                 grant_s;
  logic                 resp_s;
  logic [GW-1:0]        win_s;
  logic                 win_write_s;
  logic [31:0]          win_addr_s;
  logic [LINE-1:0]      win_wdata_s;
  logic [NUM_PORTS-1:0] port_resp_s;
  logic [LINE-1:0]      port_rdata_s;

  assign req_s     = bus.port_read | bus.port_write;
  assign any_req_s = |req_s;
  assign grant_s   = (state_q == IDLE) && any_req_s;
  // A mem_resp outside BUSY (e.g. a late one after reset) is ignored here.
  assign resp_s    = (state_q == BUSY) && bus.mem_resp;

`ifdef MEM_ARBITER_RR_EN
  logic [GW-1:0] rr_ptr_q;
  logic [GW-1:0] rr_idx_s;
  logic          found_s;

  // Round-robin pick: scan from the slot after the previous winner.
  always_comb begin
    win_s    = '0;
    rr_idx_s = '0;
    found_s  = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      rr_idx_s = GW'((int'(rr_ptr_q) + k) % NUM_PORTS);
      win_s    = (!found_s && req_s[rr_idx_s]) ? rr_idx_s : win_s;
      found_s  = found_s | req_s[rr_idx_s];
    end
  end

  // Pointer remembers the last winner; reset value makes channel 0 first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= GW'(NUM_PORTS - 1);
    end else if (grant_s) begin
      rr_ptr_q <= win_s;
    end else begin
      rr_ptr_q <= rr_ptr_q;
    end
  end
`else
  // Fixed priority pick: descending scan so the lowest requester wins.
  always_comb begin
    win_s = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      win_s = req_s[GW'(k)] ? GW'(k) : win_s;
    end
  end
`endif

  // Winner's operation, address and line; write dominates a simultaneous read.
  always_comb begin
    win_write_s = bus.port_write[win_s];
    win_addr_s  = bus.port_address[32*int'(win_s) +: 32];
    win_wdata_s = bus.port_wdata[LINE*int'(win_s) +: LINE];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_req_s ? BUSY : IDLE;
      BUSY:    state_d = bus.mem_resp ? DONE : BUSY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction capture: downstream outputs are registered at grant and held
  // until mem_resp, so requester activity during BUSY cannot disturb them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q       <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= 32'h0000_0000;
      mem_wdata_q   <= '0;
    end else if (grant_s) begin
      grant_q       <= win_s;
      mem_read_q    <= ~win_write_s;
      mem_write_q   <= win_write_s;
      mem_address_q <= win_addr_s;
      mem_wdata_q   <= win_wdata_s;
    end else if (resp_s) begin
      grant_q       <= grant_q;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= 32'h0000_0000;
      mem_wdata_q   <= '0;
    end else begin
      grant_q       <= grant_q;
      mem_read_q    <= mem_read_q;
      mem_write_q   <= mem_write_q;
      mem_address_q <= mem_address_q;
      mem_wdata_q   <= mem_wdata_q;
    end
  end

  // FSM outputs: completion pulse and read line pass through in the mem_resp cycle.
  always_comb begin
    port_resp_s  = '0;
    port_rdata_s = '0;
    if (resp_s) begin
      port_resp_s[grant_q] = 1'b1;
      port_rdata_s         = bus.mem_rdata;
    end else begin
      port_resp_s  = '0;
      port_rdata_s = '0;
    end
  end

  assign bus.port_resp   = port_resp_s;
  assign bus.port_rdata  = port_rdata_s;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;
endmodule
